imu_filter: RTL and testbench

Conditioning stage directly downstream of the IMU SPI readout state machine. Consumes one signed 16-bit raw axis sample per strobe and estimates a zero-offset bias from a calibration burst. After calibration, it subtracts the bias, saturates the result, and produces a boxcar moving average for the attitude/control logic. One instance is used per IMU axis.

---
 rtl/imu_filter.sv | 98 +++++++++
 tb/tb_imu_filter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/imu_filter.sv
// rtl/imu_filter.sv - per-axis IMU conditioning: bias calibration, centering with saturation, boxcar average
module imu_filter #(
  parameter int WIN_LOG2 = 3,
  parameter int CAL_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        cal_start,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [15:0] bias,
  output logic        calibrated
);

  localparam int AW  = 16 + CAL_LOG2;
  localparam int SW  = 16 + WIN_LOG2;
  localparam int WIN = 1 << WIN_LOG2;

  typedef enum logic [1:0] {ST_CAL, ST_FILL, ST_RUN} state_t;

  state_t                state;
  logic signed [AW-1:0]  acc;
  logic [CAL_LOG2-1:0]   cal_cnt;
  logic signed [SW-1:0]  sum;
  logic [WIN_LOG2-1:0]   wptr;
  logic signed [15:0]    win_buf [WIN];

  logic signed [AW-1:0]  acc_next;
  logic signed [16:0]    diff;
  logic signed [15:0]    centered;
  logic signed [SW-1:0]  new_sum;

  always_comb begin
    acc_next = acc + {{CAL_LOG2{in_data[15]}}, in_data};
    diff     = {in_data[15], in_data} - {bias[15], bias};
    // 17-bit difference overflows 16 bits exactly when the top two bits disagree
    if (diff[16] != diff[15])
      centered = diff[16] ? 16'sh8000 : 16'sh7fff;
    else
      centered = diff[15:0];
    new_sum = sum + {{WIN_LOG2{centered[15]}}, centered}
                  - {{WIN_LOG2{win_buf[wptr][15]}}, win_buf[wptr]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_CAL;
      acc        <= '0;
      cal_cnt    <= '0;
      sum        <= '0;
      wptr       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      bias       <= '0;
      calibrated <= 1'b0;
      for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (cal_start) begin
        state      <= ST_CAL;
        acc        <= '0;
        cal_cnt    <= '0;
        calibrated <= 1'b0;
      end else if (in_valid) begin
        case (state)
          ST_CAL: begin
            acc     <= acc_next;
            cal_cnt <= cal_cnt + 1'b1;
            if (cal_cnt == '1) begin
              // top 16 bits of the sum are the arithmetic shift by CAL_LOG2
              bias       <= acc_next[AW-1:CAL_LOG2];
              calibrated <= 1'b1;
              state      <= ST_FILL;
              sum        <= '0;
              wptr       <= '0;
              for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
            end
          end
          ST_FILL, ST_RUN: begin
            sum           <= new_sum;
            win_buf[wptr] <= centered;
            wptr          <= wptr + 1'b1;
            // during FILL, wptr doubles as the fill counter since both start at 0
            if (state == ST_RUN || wptr == '1) begin
              out_valid <= 1'b1;
              out_data  <= new_sum[SW-1:WIN_LOG2];
              state     <= ST_RUN;
            end
          end
          default: state <= ST_CAL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imu_filter.sv
// tb/tb_imu_filter.sv - directed self-checking bench for imu_filter
module tb_imu_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        cal_start = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [15:0] bias;
  logic        calibrated;

  int checks = 0;
  int errors = 0;

  imu_filter #(.WIN_LOG2(3), .CAL_LOG2(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .cal_start(cal_start), .out_valid(out_valid), .out_data(out_data),
    .bias(bias), .calibrated(calibrated)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // inputs change and outputs are sampled on the falling edge
  task automatic push(input int d, input logic cs = 1'b0);
    in_valid  = 1'b1;
    in_data   = d[15:0];
    cal_start = cs;
    @(negedge clk);
    in_valid  = 1'b0;
    cal_start = 1'b0;
  endtask

  task automatic recal();
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
  endtask

  task automatic cal_run(input string tag, input int v, input int last, input int exp_bias);
    int nv = 0;
    for (int i = 0; i < 63; i++) begin
      push(v);
      nv += int'(out_valid);
    end
    check({tag, " cal not yet"}, int'(calibrated), 0);
    push(last);
    nv += int'(out_valid);
    check({tag, " calibrated"}, int'(calibrated), 1);
    check({tag, " bias"}, $signed(bias), exp_bias);
    check({tag, " no out_valid in CAL"}, nv, 0);
  endtask

  task automatic win_run(input string tag, input int v, input int last, input int exp_out);
    int nv = 0;
    for (int i = 0; i < 7; i++) begin
      push(v);
      nv += int'(out_valid);
    end
    check({tag, " no out_valid in FILL"}, nv, 0);
    push(last);
    check({tag, " first out_valid"}, int'(out_valid), 1);
    check({tag, " out_data"}, $signed(out_data), exp_out);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " out_valid"}, int'(out_valid), 0);
    check({tag, " out_data"}, $signed(out_data), 0);
    check({tag, " bias"}, $signed(bias), 0);
    check({tag, " calibrated"}, int'(calibrated), 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset("reset");

    cal_run("cal1000", 1000, 1000, 1000);
    win_run("fill1008", 1008, 1008, 8);
    for (int k = 1; k <= 8; k++) begin
      push(1016);
      check($sformatf("step valid %0d", k), int'(out_valid), 1);
      check($sformatf("step data %0d", k), $signed(out_data), 8 + k);
    end
    @(negedge clk);
    check("idle no strobe", int'(out_valid), 0);
    check("idle hold data", $signed(out_data), 16);

    push(1016, 1'b1);
    check("recal suppress valid", int'(out_valid), 0);
    check("recal calibrated low", int'(calibrated), 0);
    check("recal bias held", $signed(bias), 1000);
    cal_run("round+1", 0, 1, 0);

    win_run("win -1", 0, -1, -1);

    recal();
    cal_run("round-1", 0, -1, -1);

    recal();
    cal_run("cal-32000", -32000, -32000, -32000);
    win_run("sat pos", 32767, 32767, 32767);

    recal();
    cal_run("cal32000", 32000, 32000, 32000);
    win_run("sat neg", -32768, -32768, -32768);

    recal();
    cal_run("cal500", 500, 500, 500);
    begin
      int nv = 0;
      for (int i = 0; i < 5; i++) begin
        push(600);
        nv += int'(out_valid);
      end
      check("partial fill no strobe", nv, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("mid-fill reset");
    cal_run("cal200", 200, 200, 200);
    win_run("post-reset fill", 216, 216, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
